// File: rtl/cu_pkg.sv
// Shared definitions for the multicycle control unit: state encodings,
// opcode/funct values, ULA operation codes, datapath mux-select encodings,
// and the decode helpers used by the FSM.
package cu_pkg;

  localparam int unsigned STATE_W    = 5;
  localparam int unsigned WAIT_CNT_W = 3;  // holds MEM_WAIT+1 (max 4)

  typedef logic [STATE_W-1:0] state_t;
  typedef logic [5:0]         op_t;
  typedef logic [2:0]         ula_op_t;
  typedef logic [1:0]         sel2_t;
  typedef logic [2:0]         sel3_t;

  // FSM states
  localparam state_t S_RESET      = 5'd0;
  localparam state_t S_FETCH      = 5'd1;
  localparam state_t S_FETCH_WAIT = 5'd2;
  localparam state_t S_DECODE     = 5'd3;
  localparam state_t S_EXEC_R     = 5'd4;
  localparam state_t S_WB_R       = 5'd5;
  localparam state_t S_EXEC_I     = 5'd6;
  localparam state_t S_WB_I       = 5'd7;
  localparam state_t S_ADDR       = 5'd8;
  localparam state_t S_MEM_RD     = 5'd9;
  localparam state_t S_WB_LW      = 5'd10;
  localparam state_t S_MEM_WR     = 5'd11;
  localparam state_t S_BRANCH     = 5'd12;
  localparam state_t S_JUMP       = 5'd13;
  localparam state_t S_RTE        = 5'd14;
  localparam state_t S_EXC_SAVE   = 5'd15;
  localparam state_t S_EXC_VEC    = 5'd16;
  localparam state_t S_HALT       = 5'd17;

  // Opcodes
  localparam op_t OP_RTYPE = 6'h00;
  localparam op_t OP_J     = 6'h02;
  localparam op_t OP_BEQ   = 6'h04;
  localparam op_t OP_BNE   = 6'h05;
  localparam op_t OP_ADDI  = 6'h08;
  localparam op_t OP_LW    = 6'h23;
  localparam op_t OP_SW    = 6'h2B;

  // R-type funct values
  localparam op_t FN_BREAK = 6'h0D;
  localparam op_t FN_RTE   = 6'h13;
  localparam op_t FN_ADD   = 6'h20;
  localparam op_t FN_SUB   = 6'h22;
  localparam op_t FN_AND   = 6'h24;

  // ULA operations
  localparam ula_op_t ULA_PASS = 3'b000;
  localparam ula_op_t ULA_ADD  = 3'b001;
  localparam ula_op_t ULA_SUB  = 3'b010;
  localparam ula_op_t ULA_AND  = 3'b011;
  localparam ula_op_t ULA_CMP  = 3'b111;

  // ULA A-input select
  localparam sel2_t ULAA_PC = 2'b00;
  localparam sel2_t ULAA_A  = 2'b01;
  localparam sel2_t ULAA_B  = 2'b10;

  // ULA B-input select
  localparam sel2_t ULAB_B        = 2'b00;
  localparam sel2_t ULAB_FOUR     = 2'b01;
  localparam sel2_t ULAB_SEXT     = 2'b10;
  localparam sel2_t ULAB_SEXT_SL2 = 2'b11;

  // PC source select
  localparam sel3_t PCSRC_ULA    = 3'b000;
  localparam sel3_t PCSRC_ALUOUT = 3'b001;
  localparam sel3_t PCSRC_JUMP   = 3'b010;
  localparam sel3_t PCSRC_EXCVEC = 3'b011;
  localparam sel3_t PCSRC_EPC    = 3'b100;

  // Memory address select
  localparam sel2_t ADDR_PC     = 2'b00;
  localparam sel2_t ADDR_ULA    = 2'b01;
  localparam sel2_t ADDR_ALUOUT = 2'b10;

  // Register-file write port selects
  localparam logic WREG_RT      = 1'b0;
  localparam logic WREG_RD      = 1'b1;
  localparam logic WDATA_ALUOUT = 1'b0;
  localparam logic WDATA_MEM    = 1'b1;

  // State following DECODE for a given instruction; anything unrecognised traps.
  function automatic state_t decode_next(op_t op, op_t fn);
    state_t s;
    s = S_EXC_SAVE;
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_ADD, FN_SUB, FN_AND: s = S_EXEC_R;
          FN_RTE:                 s = S_RTE;
          FN_BREAK:               s = S_HALT;
          default:                s = S_EXC_SAVE;
        endcase
      end
      OP_ADDI:        s = S_EXEC_I;
      OP_LW, OP_SW:   s = S_ADDR;
      OP_BEQ, OP_BNE: s = S_BRANCH;
      OP_J:           s = S_JUMP;
      default:        s = S_EXC_SAVE;
    endcase
    return s;
  endfunction

  // ULA operation for a decoded R-type ALU funct.
  function automatic ula_op_t funct_ula(op_t fn);
    ula_op_t u;
    case (fn)
      FN_SUB:  u = ULA_SUB;
      FN_AND:  u = ULA_AND;
      default: u = ULA_ADD;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Datapath <-> control unit bundle.
//   inputs to control : OPCODE, FUNCT (IR fields), Of/Zero/Eq (ULA flags)
//   outputs of control: write enables, ULA op, mux selects, halted
// modport slave  : the control unit
// modport master : the datapath (or a bench standing in for it)
interface control_unit_if;
  import cu_pkg::*;

  op_t     OPCODE;
  op_t     FUNCT;
  logic    Of;
  logic    Zero;
  logic    Eq;

  logic    PC_w;
  logic    MEM_w;
  logic    IR_w;
  logic    RB_w;
  logic    AB_w;
  logic    ALUOut_w;
  logic    EPC_w;
  ula_op_t ULA_c;
  sel2_t   M_ULAA;
  sel2_t   M_ULAB;
  sel3_t   M_PC_src;
  sel2_t   Mux_addr;
  logic    M_WREG;
  logic    M_WDATA;
  logic    halted;

  modport slave (
    input  OPCODE, FUNCT, Of, Zero, Eq,
    output PC_w, MEM_w, IR_w, RB_w, AB_w, ALUOut_w, EPC_w,
           ULA_c, M_ULAA, M_ULAB, M_PC_src, Mux_addr, M_WREG, M_WDATA, halted
  );

  modport master (
    output OPCODE, FUNCT, Of, Zero, Eq,
    input  PC_w, MEM_w, IR_w, RB_w, AB_w, ALUOut_w, EPC_w,
           ULA_c, M_ULAA, M_ULAB, M_PC_src, Mux_addr, M_WREG, M_WDATA, halted
  );
endinterface

// File: rtl/cu_wait_cnt.sv
// Memory-latency wait counter.
//   clk, reset : clock, async active-high reset
//   load       : (re)load the counter with load_val
//   load_val   : number of cycles the following wait state lasts
//   done_c     : high in the last cycle of the wait window
module cu_wait_cnt
  import cu_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [WAIT_CNT_W-1:0] load_val,
  output logic                  done_c
);

  logic [WAIT_CNT_W-1:0] cnt;

  // Down counter, parks at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - WAIT_CNT_W'(1);
    end
  end

  assign done_c = (cnt == WAIT_CNT_W'(1));

endmodule

// File: rtl/control_unit.sv
// Multicycle MIPS-style control unit.
//   clk   : system clock
//   reset : asynchronous active-high reset, forces the RESET state at once
//   bus   : control_unit_if.slave (IR fields + ULA flags in, enables/selects out)
// Parameter MEM_WAIT (1..3): memory wait cycles after each access.
// Macro CTRL_OVERFLOW_EXC_EN: when defined, Of during add/sub/addi execution
// diverts to the exception path instead of writing the register file.
// Outputs are a decode of the state register; the one exception is PC_w in
// BRANCH, which must follow Eq from the compare done in that same cycle.
module control_unit
  import cu_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 1
) (
  input logic           clk,
  input logic           reset,
  control_unit_if.slave bus
);

  state_t                state;
  state_t                state_nxt;
  logic                  cnt_load;
  logic [WAIT_CNT_W-1:0] cnt_val;
  logic                  wait_done_c;

  // Zero is not needed by any state; Of only when the overflow trap is built in.
  logic unused_flags;
  assign unused_flags = ^{bus.Zero, bus.Of};

  cu_wait_cnt u_wait_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .done_c   (wait_done_c)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_RESET;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and per-state outputs
  always_comb begin
    state_nxt    = state;
    cnt_load     = 1'b0;
    cnt_val      = WAIT_CNT_W'(MEM_WAIT);
    bus.PC_w     = 1'b0;
    bus.MEM_w    = 1'b0;
    bus.IR_w     = 1'b0;
    bus.RB_w     = 1'b0;
    bus.AB_w     = 1'b0;
    bus.ALUOut_w = 1'b0;
    bus.EPC_w    = 1'b0;
    bus.ULA_c    = ULA_PASS;
    bus.M_ULAA   = ULAA_PC;
    bus.M_ULAB   = ULAB_B;
    bus.M_PC_src = PCSRC_ULA;
    bus.Mux_addr = ADDR_PC;
    bus.M_WREG   = WREG_RT;
    bus.M_WDATA  = WDATA_ALUOUT;
    bus.halted   = 1'b0;

    case (state)
      S_RESET: state_nxt = S_FETCH;

      // Read instruction at PC while the ULA advances PC by 4.
      S_FETCH: begin
        bus.Mux_addr = ADDR_PC;
        bus.M_ULAA   = ULAA_PC;
        bus.M_ULAB   = ULAB_FOUR;
        bus.ULA_c    = ULA_ADD;
        bus.PC_w     = 1'b1;
        bus.M_PC_src = PCSRC_ULA;
        cnt_load     = 1'b1;
        state_nxt    = S_FETCH_WAIT;
      end

      S_FETCH_WAIT: begin
        bus.Mux_addr = ADDR_PC;
        if (wait_done_c) begin
          bus.IR_w  = 1'b1;
          state_nxt = S_DECODE;
        end
      end

      // Latch A/B and precompute the branch target.
      S_DECODE: begin
        bus.AB_w     = 1'b1;
        bus.ALUOut_w = 1'b1;
        bus.M_ULAA   = ULAA_PC;
        bus.M_ULAB   = ULAB_SEXT_SL2;
        bus.ULA_c    = ULA_ADD;
        state_nxt    = decode_next(bus.OPCODE, bus.FUNCT);
      end

      S_EXEC_R: begin
        bus.M_ULAA   = ULAA_A;
        bus.M_ULAB   = ULAB_B;
        bus.ULA_c    = funct_ula(bus.FUNCT);
        bus.ALUOut_w = 1'b1;
        state_nxt    = S_WB_R;
`ifdef CTRL_OVERFLOW_EXC_EN
        if (bus.Of && (bus.FUNCT != FN_AND)) begin
          state_nxt = S_EXC_SAVE;
        end
`endif
      end

      S_WB_R: begin
        bus.RB_w    = 1'b1;
        bus.M_WREG  = WREG_RD;
        bus.M_WDATA = WDATA_ALUOUT;
        state_nxt   = S_FETCH;
      end

      S_EXEC_I: begin
        bus.M_ULAA   = ULAA_A;
        bus.M_ULAB   = ULAB_SEXT;
        bus.ULA_c    = ULA_ADD;
        bus.ALUOut_w = 1'b1;
        state_nxt    = S_WB_I;
`ifdef CTRL_OVERFLOW_EXC_EN
        if (bus.Of) begin
          state_nxt = S_EXC_SAVE;
        end
`endif
      end

      S_WB_I: begin
        bus.RB_w    = 1'b1;
        bus.M_WREG  = WREG_RT;
        bus.M_WDATA = WDATA_ALUOUT;
        state_nxt   = S_FETCH;
      end

      // Effective address; also arms the load window: the access cycle
      // itself plus MEM_WAIT wait cycles.
      S_ADDR: begin
        bus.M_ULAA   = ULAA_A;
        bus.M_ULAB   = ULAB_SEXT;
        bus.ULA_c    = ULA_ADD;
        bus.ALUOut_w = 1'b1;
        cnt_load     = 1'b1;
        cnt_val      = WAIT_CNT_W'(MEM_WAIT + 1);
        state_nxt    = (bus.OPCODE == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end

      S_MEM_RD: begin
        bus.Mux_addr = ADDR_ALUOUT;
        if (wait_done_c) begin
          state_nxt = S_WB_LW;
        end
      end

      S_WB_LW: begin
        bus.RB_w    = 1'b1;
        bus.M_WREG  = WREG_RT;
        bus.M_WDATA = WDATA_MEM;
        state_nxt   = S_FETCH;
      end

      S_MEM_WR: begin
        bus.Mux_addr = ADDR_ALUOUT;
        bus.MEM_w    = 1'b1;
        state_nxt    = S_FETCH;
      end

      // Compare A,B; the target already sits in ALUOut from DECODE.
      S_BRANCH: begin
        bus.M_ULAA   = ULAA_A;
        bus.M_ULAB   = ULAB_B;
        bus.ULA_c    = ULA_CMP;
        bus.M_PC_src = PCSRC_ALUOUT;
        bus.PC_w     = (bus.OPCODE == OP_BEQ) ? bus.Eq : ~bus.Eq;
        state_nxt    = S_FETCH;
      end

      S_JUMP: begin
        bus.PC_w     = 1'b1;
        bus.M_PC_src = PCSRC_JUMP;
        state_nxt    = S_FETCH;
      end

      S_RTE: begin
        bus.PC_w     = 1'b1;
        bus.M_PC_src = PCSRC_EPC;
        state_nxt    = S_FETCH;
      end

      // PC already points past the faulting instruction; save PC-4.
      S_EXC_SAVE: begin
        bus.M_ULAA = ULAA_PC;
        bus.M_ULAB = ULAB_FOUR;
        bus.ULA_c  = ULA_SUB;
        bus.EPC_w  = 1'b1;
        state_nxt  = S_EXC_VEC;
      end

      S_EXC_VEC: begin
        bus.PC_w     = 1'b1;
        bus.M_PC_src = PCSRC_EXCVEC;
        state_nxt    = S_FETCH;
      end

      S_HALT: begin
        bus.halted = 1'b1;
        state_nxt  = S_HALT;
      end

      default: state_nxt = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;

  localparam int MW = 1;

`ifdef CTRL_OVERFLOW_EXC_EN
  localparam bit OVF_EXC = 1'b1;
`else
  localparam bit OVF_EXC = 1'b0;
`endif

  // enable vector order: PC MEM IR RB AB ALUOut EPC halted
  localparam logic [7:0] E_NONE = 8'h00;
  localparam logic [7:0] E_PC   = 8'h80;
  localparam logic [7:0] E_MEM  = 8'h40;
  localparam logic [7:0] E_IR   = 8'h20;
  localparam logic [7:0] E_RB   = 8'h10;
  localparam logic [7:0] E_AB   = 8'h08;
  localparam logic [7:0] E_ALUO = 8'h04;
  localparam logic [7:0] E_EPC  = 8'h02;
  localparam logic [7:0] E_HALT = 8'h01;

  // select vector: ULA_c[13:11] M_ULAA[10:9] M_ULAB[8:7] M_PC_src[6:4] Mux_addr[3:2] M_WREG[1] M_WDATA[0]
  localparam int F_ULA = 11, F_ULAA = 9, F_ULAB = 7, F_PCS = 4, F_MA = 2, F_WREG = 1, F_WDATA = 0;

  typedef struct {
    string       tag;
    logic [7:0]  en;
    logic [13:0] sel;
    logic [13:0] msk;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  control_unit_if bus();

  control_unit #(.MEM_WAIT(MW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(string tag, logic [7:0] en);
    exp_t r;
    r.tag = tag;
    r.en  = en;
    r.sel = '0;
    r.msk = '0;
    return r;
  endfunction

  function automatic exp_t fld(exp_t r, int lo, int w, logic [2:0] v);
    for (int i = 0; i < w; i++) begin
      r.sel[lo+i] = v[i];
      r.msk[lo+i] = 1'b1;
    end
    return r;
  endfunction

  // Monitor: one expected record per cycle, compared mid-cycle.
  always @(negedge clk) begin
    exp_t        e;
    logic [7:0]  ae;
    logic [13:0] as;
    if (sb.size() > 0) begin
      e  = sb.pop_front();
      ae = {bus.PC_w, bus.MEM_w, bus.IR_w, bus.RB_w, bus.AB_w, bus.ALUOut_w, bus.EPC_w, bus.halted};
      as = {bus.ULA_c, bus.M_ULAA, bus.M_ULAB, bus.M_PC_src, bus.Mux_addr, bus.M_WREG, bus.M_WDATA};
      checks++;
      if (ae !== e.en) begin
        errors++;
        $display("FAIL %s enables(PC,MEM,IR,RB,AB,ALUOut,EPC,halted) got %b want %b at %0t", e.tag, ae, e.en, $time);
      end
      if (e.msk != '0) begin
        checks++;
        if ((as & e.msk) !== (e.sel & e.msk)) begin
          errors++;
          $display("FAIL %s selects got %b want %b mask %b at %0t", e.tag, as, e.sel, e.msk, $time);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation got stuck, want finish before %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic push_exc(input string t);
    sb.push_back(fld(fld(fld(mk({t, ".epc"}, E_EPC), F_ULA, 3, 3'd2), F_ULAA, 2, 3'd0), F_ULAB, 2, 3'd1));
    sb.push_back(fld(mk({t, ".vec"}, E_PC), F_PCS, 3, 3'd3));
  endtask

  // Fetch (1 + MW cycles) and decode (1 cycle), common to every instruction.
  task automatic push_front_end(input string t);
    sb.push_back(fld(fld(fld(fld(fld(mk({t, ".fetch"}, E_PC), F_ULA, 3, 3'd1), F_ULAA, 2, 3'd0),
                         F_ULAB, 2, 3'd1), F_PCS, 3, 3'd0), F_MA, 2, 3'd0));
    for (int i = 1; i <= MW; i++)
      sb.push_back(fld(mk({t, ".fwait"}, (i == MW) ? E_IR : E_NONE), F_MA, 2, 3'd0));
    sb.push_back(fld(fld(fld(mk({t, ".decode"}, E_AB | E_ALUO), F_ULA, 3, 3'd1), F_ULAA, 2, 3'd0), F_ULAB, 2, 3'd3));
  endtask

  function automatic exp_t addr_rec(string t);
    return fld(fld(fld(mk(t, E_ALUO), F_ULA, 3, 3'd1), F_ULAA, 2, 3'd1), F_ULAB, 2, 3'd2);
  endfunction

  task automatic set_inputs(input logic [5:0] op, input logic [5:0] fn, input logic eq, input logic of);
    bus.OPCODE = op;
    bus.FUNCT  = fn;
    bus.Eq     = eq;
    bus.Of     = of;
    bus.Zero   = 1'($urandom);
  endtask

  // Issue one instruction at the start of its FETCH cycle; queue its full
  // expected cycle trace and return at the start of the next FETCH.
  task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic eq, input logic of, input string t);
    int   n0;
    int   n;
    logic take;
    n0 = sb.size();
    set_inputs(op, fn, eq, of);
    push_front_end(t);
    if (op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24)) begin
      sb.push_back(fld(fld(fld(mk({t, ".exec"}, E_ALUO),
                               F_ULA, 3, (fn == 6'h20) ? 3'd1 : (fn == 6'h22) ? 3'd2 : 3'd3),
                           F_ULAA, 2, 3'd1), F_ULAB, 2, 3'd0));
      if (OVF_EXC && of && fn != 6'h24) push_exc(t);
      else sb.push_back(fld(fld(mk({t, ".wb"}, E_RB), F_WREG, 1, 3'd1), F_WDATA, 1, 3'd0));
    end else if (op == 6'h08) begin
      sb.push_back(addr_rec({t, ".exec"}));
      if (OVF_EXC && of) push_exc(t);
      else sb.push_back(fld(fld(mk({t, ".wb"}, E_RB), F_WREG, 1, 3'd0), F_WDATA, 1, 3'd0));
    end else if (op == 6'h23) begin
      sb.push_back(addr_rec({t, ".addr"}));
      for (int i = 0; i < MW + 1; i++) sb.push_back(fld(mk({t, ".memrd"}, E_NONE), F_MA, 2, 3'd2));
      sb.push_back(fld(fld(mk({t, ".wb"}, E_RB), F_WREG, 1, 3'd0), F_WDATA, 1, 3'd1));
    end else if (op == 6'h2B) begin
      sb.push_back(addr_rec({t, ".addr"}));
      sb.push_back(fld(mk({t, ".memwr"}, E_MEM), F_MA, 2, 3'd2));
    end else if (op == 6'h04 || op == 6'h05) begin
      take = (op == 6'h04) ? eq : ~eq;
      if (take)
        sb.push_back(fld(fld(fld(fld(mk({t, ".branch"}, E_PC), F_ULA, 3, 3'd7), F_ULAA, 2, 3'd1), F_ULAB, 2, 3'd0), F_PCS, 3, 3'd1));
      else
        sb.push_back(fld(fld(fld(mk({t, ".branch"}, E_NONE), F_ULA, 3, 3'd7), F_ULAA, 2, 3'd1), F_ULAB, 2, 3'd0));
    end else if (op == 6'h02) begin
      sb.push_back(fld(mk({t, ".jump"}, E_PC), F_PCS, 3, 3'd2));
    end else if (op == 6'h00 && fn == 6'h13) begin
      sb.push_back(fld(mk({t, ".rte"}, E_PC), F_PCS, 3, 3'd4));
    end else if (op == 6'h00 && fn == 6'h0D) begin
      for (int i = 0; i < 100; i++) sb.push_back(mk({t, ".halt"}, E_HALT));
    end else begin
      push_exc(t);
    end
    n = sb.size() - n0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold reset for n cycles expecting every output at zero, release between
  // edges; returns one step after the first FETCH edge.
  task automatic do_reset(input int n);
    exp_t z;
    reset = 1'b1;
    z = mk("reset", E_NONE);
    z.msk = '1;
    for (int i = 0; i < n; i++) sb.push_back(z);
    repeat (n) @(negedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // lw interrupted by reset during its memory read window.
  task automatic lw_abort();
    set_inputs(6'h23, 6'h05, 1'b0, 1'b0);
    push_front_end("lw_abort");
    sb.push_back(addr_rec("lw_abort.addr"));
    sb.push_back(fld(mk("lw_abort.memrd", E_NONE), F_MA, 2, 3'd2));
    repeat (MW + 3) @(posedge clk);
    @(negedge clk);
    #1;
    do_reset(3);
  endtask

  logic [5:0] bad_op[4] = '{6'h3F, 6'h01, 6'h10, 6'h2A};
  logic [5:0] bad_fn[3] = '{6'h00, 6'h21, 6'h3F};
  logic [5:0] r_fn[3]   = '{6'h20, 6'h22, 6'h24};

  initial begin
    int         k;
    logic [5:0] op;
    logic [5:0] fn;
    set_inputs(6'h00, 6'h00, 1'b0, 1'b0);
    #2;
    do_reset(3);

    issue(6'h00, 6'h20, 1'b0, 1'b0, "add");
    issue(6'h00, 6'h22, 1'b1, 1'b0, "sub");
    issue(6'h00, 6'h24, 1'b0, 1'b1, "and_of");
    issue(6'h08, 6'h11, 1'b0, 1'b0, "addi");
    issue(6'h23, 6'h02, 1'b0, 1'b0, "lw");
    issue(6'h2B, 6'h3C, 1'b0, 1'b0, "sw");
    issue(6'h04, 6'h00, 1'b1, 1'b0, "beq_taken");
    issue(6'h04, 6'h00, 1'b0, 1'b0, "beq_not");
    issue(6'h05, 6'h00, 1'b1, 1'b0, "bne_not");
    issue(6'h05, 6'h00, 1'b0, 1'b0, "bne_taken");
    issue(6'h02, 6'h0D, 1'b0, 1'b0, "j");
    issue(6'h00, 6'h13, 1'b0, 1'b0, "rte");
    issue(6'h3F, 6'h00, 1'b0, 1'b0, "illegal_op");
    issue(6'h00, 6'h21, 1'b0, 1'b0, "illegal_fn");
    issue(6'h00, 6'h20, 1'b0, 1'b1, "add_ovf");
    issue(6'h08, 6'h01, 1'b0, 1'b1, "addi_ovf");
    lw_abort();
    issue(6'h00, 6'h22, 1'b0, 1'b0, "sub_after_abort");

    for (int i = 0; i < 80; i++) begin
      k  = int'($urandom_range(0, 9));
      fn = 6'($urandom);
      case (k)
        0, 1, 2: begin op = 6'h00; fn = r_fn[k]; end
        3:       op = 6'h08;
        4:       op = 6'h23;
        5:       op = 6'h2B;
        6:       op = 6'h04;
        7:       op = 6'h05;
        8:       if ($urandom_range(0, 1) == 0) op = 6'h02; else begin op = 6'h00; fn = 6'h13; end
        default: if ($urandom_range(0, 1) == 0) op = bad_op[$urandom_range(0, 3)];
                 else begin op = 6'h00; fn = bad_fn[$urandom_range(0, 2)]; end
      endcase
      issue(op, fn, 1'($urandom), 1'($urandom), "rand");
    end

    issue(6'h00, 6'h0D, 1'b0, 1'b0, "break");
    do_reset(2);
    issue(6'h00, 6'h20, 1'b1, 1'b0, "add_after_halt");

    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left %0d records want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
